// File: rtl/fsm_stimulus_gen.sv
// Initiator side of the start/fg/detector handshake: issues start then fg strobes on command,
// then measures fg-to-detector latency in clock cycles or flags a timeout.
module fsm_stimulus_gen #(
  parameter int START_WIDTH = 2,
  parameter int FG_LEAD     = 1000,
  parameter int TIMEOUT     = 500_000,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  output logic             start_signal,
  output logic             fg_signal,
  input  logic             detector_signal,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LEAD  = 3'd2,
    S_FG    = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_WIDTH - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST   = CNT_W'((FG_LEAD > 0) ? FG_LEAD - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state, next_state;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic             det_q, det_rise, finish;
  logic             start_nxt, fg_nxt, busy_nxt, timeout_nxt;
  logic [CNT_W-1:0] latency_nxt;

  // A detector level that is already high never looks like a fresh response.
  assign det_rise = detector_signal & ~det_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      counter      <= '0;
      det_q        <= 1'b0;
      start_signal <= 1'b0;
      fg_signal    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      latency      <= '0;
    end else begin
      state        <= next_state;
      counter      <= counter_nxt;
      det_q        <= detector_signal;
      start_signal <= start_nxt;
      fg_signal    <= fg_nxt;
      busy         <= busy_nxt;
      done         <= finish;
      timeout      <= timeout_nxt;
      latency      <= latency_nxt;
    end
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = cmd_start ? S_START : S_IDLE;
      S_START: begin
        if (cmd_abort)                 next_state = S_IDLE;
        else if (counter == START_LAST) next_state = (FG_LEAD == 0) ? S_FG : S_LEAD;
        else                           next_state = S_START;
      end
      S_LEAD: begin
        if (cmd_abort)                 next_state = S_IDLE;
        else if (counter == LEAD_LAST) next_state = S_FG;
        else                           next_state = S_LEAD;
      end
      S_FG:    next_state = cmd_abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (cmd_abort || det_rise || counter == TIMEOUT_CNT) next_state = S_IDLE;
        else                                                 next_state = S_WAIT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    start_nxt   = (next_state == S_START);
    fg_nxt      = (next_state == S_FG);
    busy_nxt    = (next_state != S_IDLE);
    finish      = (state == S_WAIT) && !cmd_abort && (det_rise || counter == TIMEOUT_CNT);
    timeout_nxt = finish ? !det_rise : timeout;
    latency_nxt = finish ? counter : latency;
    // Counter restarts on every phase entry except WAIT, where it continues from F (=0).
    if (next_state == S_IDLE || (next_state != state && next_state != S_WAIT))
      counter_nxt = '0;
    else
      counter_nxt = counter + 1'b1;
  end

endmodule

// File: tb/tb_fsm_stimulus_gen.sv
// Bench for fsm_stimulus_gen: strobe timing checked per cycle, done/latency/timeout results
// checked against a queue of expectations pushed when each sequence is commanded.
module tb_fsm_stimulus_gen;
  localparam int SW = 2;
  localparam int FL = 3;
  localparam int TO = 20;
  localparam int CW = 32;
  localparam int F  = SW + FL + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic          detector_signal = 1'b0;
  logic          start_signal, fg_signal, busy, done, timeout;
  logic [CW-1:0] latency;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int last_lat = 0;
  int last_to = 0;

  typedef struct {
    int cyc;
    int to;
    int lat;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  fsm_stimulus_gen #(
    .START_WIDTH(SW), .FG_LEAD(FL), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .start_signal(start_signal), .fg_signal(fg_signal),
    .detector_signal(detector_signal), .busy(busy), .done(done),
    .timeout(timeout), .latency(latency)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always begin
    @(posedge clock);
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("timeout", 32'(timeout), e.to);
        check("latency", latency, e.lat);
      end
    end
  end

  // Commands a sequence in the current cycle and walks to cycle F checking strobes.
  task automatic go_to_fg(input bit with_abort, input bit pre_pulse);
    cmd_start = 1'b1;
    cmd_abort = with_abort;
    tick();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    for (int k = 1; k <= F; k++) begin
      check("start_signal", 32'(start_signal), 32'(k <= SW));
      check("fg_signal", 32'(fg_signal), 32'(k == F));
      check("busy", 32'(busy), 32'(1));
      if (pre_pulse) detector_signal = (k == 4);
      if (k < F) tick();
    end
  endtask

  // det_n > 0: detector rises at F+det_n; det_n == 0: no rise, expect timeout.
  task automatic seq(input int det_n, input bit with_abort, input bit pre_pulse, input bit poke);
    exp_t x;
    x.cyc = cyc + F + ((det_n > 0) ? det_n : TO) + 1;
    x.to  = (det_n > 0) ? 0 : 1;
    x.lat = (det_n > 0) ? det_n : TO;
    exp_q.push_back(x);
    last_lat = x.lat;
    last_to  = x.to;
    go_to_fg(with_abort, pre_pulse);
    for (int n = 1; n <= TO; n++) begin
      tick();
      check("wait_fg", 32'(fg_signal), 32'(0));
      check("wait_busy", 32'(busy), 32'(1));
      if (poke) cmd_start = (n == 2);
      if (n == det_n) begin
        detector_signal = 1'b1;
        break;
      end
    end
    cmd_start = 1'b0;
    tick();
    check("end_busy", 32'(busy), 32'(0));
    check("end_start", 32'(start_signal), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    check("rst_start", 32'(start_signal), 32'(0));
    check("rst_fg", 32'(fg_signal), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    check("rst_latency", latency, 32'(0));
    reset = 1'b0;
    tick();

    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'(0));

    // Nominal edge at F+5, then a back-to-back sequence started in the done cycle.
    seq(5, 1'b0, 1'b0, 1'b0);
    detector_signal = 1'b0;
    seq(7, 1'b0, 1'b0, 1'b0);
    detector_signal = 1'b0;
    tick();
    tick();

    // No edge at all, with a cmd_start poked while busy.
    seq(0, 1'b0, 1'b0, 1'b1);

    // Detector stuck high: no edge, then a real edge at F+3.
    detector_signal = 1'b1;
    tick();
    tick();
    seq(0, 1'b0, 1'b0, 1'b0);
    detector_signal = 1'b0;
    tick();
    seq(3, 1'b0, 1'b0, 1'b0);
    detector_signal = 1'b0;

    // Start and abort together in IDLE, detector pulse during LEAD ignored.
    seq(4, 1'b1, 1'b1, 1'b0);
    detector_signal = 1'b0;
    tick();
    tick();

    // Abort during LEAD.
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    tick();
    tick();
    check("lead_busy", 32'(busy), 32'(1));
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_lead_busy", 32'(busy), 32'(0));
    check("abort_lead_start", 32'(start_signal), 32'(0));
    for (int i = 0; i < 6; i++) begin
      check("abort_lead_fg", 32'(fg_signal), 32'(0));
      tick();
    end
    check("abort_lead_latency", latency, last_lat);
    check("abort_lead_timeout", 32'(timeout), last_to);

    // Abort in the same cycle as a detector rise.
    go_to_fg(1'b0, 1'b0);
    for (int n = 1; n <= 4; n++) tick();
    detector_signal = 1'b1;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_det_busy", 32'(busy), 32'(0));
    check("abort_det_done", 32'(done), 32'(0));
    check("abort_det_latency", latency, last_lat);
    check("abort_det_timeout", 32'(timeout), last_to);
    detector_signal = 1'b0;
    tick();
    tick();

    // Reset while waiting for the detector.
    go_to_fg(1'b0, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rwait_start", 32'(start_signal), 32'(0));
    check("rwait_fg", 32'(fg_signal), 32'(0));
    check("rwait_busy", 32'(busy), 32'(0));
    check("rwait_done", 32'(done), 32'(0));
    check("rwait_timeout", 32'(timeout), 32'(0));
    check("rwait_latency", latency, 32'(0));
    last_lat = 0;
    last_to  = 0;
    tick();

    // Reset in the first START cycle, then a fresh nominal sequence.
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("rstart_start_hi", 32'(start_signal), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstart_start", 32'(start_signal), 32'(0));
    check("rstart_busy", 32'(busy), 32'(0));
    tick();
    seq(5, 1'b0, 1'b0, 1'b0);
    detector_signal = 1'b0;

    repeat (3) tick();
    check("pending_results", exp_q.size(), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
